// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses to a 32-bit word memory, with optional
// two-beat handling of accesses that cross a word boundary (enabled by LSU_MISALIGNED_EN).
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_store_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_fault_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wr_en_o,
   output logic [1:0]  mem_load_type_o,
   output logic        mem_read_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t      state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         lo_q     <= 32'h0;
         hi_q     <= 32'h0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   logic [1:0]  off;
   logic [3:0]  size;
   logic [3:0]  mask;
   logic        legal;
   logic        split;
   logic        fault;
   logic [7:0]  mask_sh;
   logic [63:0] wdata_sh;
   logic [31:0] word_addr;
   logic [31:0] next_word;
   logic [31:0] rd;
   logic [31:0] ext;

   assign off       = addr_q[1:0];
   assign word_addr = {addr_q[31:2], 2'b00};
   assign next_word = word_addr + 32'd4;

   always_comb begin
      size = 4'd4;
      mask = 4'b1111;
      case (funct3_q[1:0])
         2'b00:   begin size = 4'd1; mask = 4'b0001; end
         2'b01:   begin size = 4'd2; mask = 4'b0011; end
         default: begin size = 4'd4; mask = 4'b1111; end
      endcase
   end

   assign legal = store_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                          : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign split = ({2'b00, off} + size) > 4'd4;

`ifdef LSU_MISALIGNED_EN
   assign fault = !legal;
`else
   assign fault = !legal || split;
`endif

   // Lanes shifted into an 8-byte window: low half is the first word, high half the next.
   assign mask_sh  = {4'b0000, mask} << off;
   assign wdata_sh = {32'h0, wdata_q} << {off, 3'b000};

   assign rd = 32'({hi_q, lo_q} >> {off, 3'b000});

   always_comb begin
      case (funct3_q)
         3'b000:  ext = {{24{rd[7]}}, rd[7:0]};
         3'b001:  ext = {{16{rd[15]}}, rd[15:0]};
         3'b100:  ext = {24'h0, rd[7:0]};
         3'b101:  ext = {16'h0, rd[15:0]};
         default: ext = rd;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      store_d         = store_q;
      funct3_d        = funct3_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      lo_d            = lo_q;
      hi_d            = hi_q;
      req_ready_o     = 1'b0;
      resp_valid_o    = 1'b0;
      resp_data_o     = 32'h0;
      resp_fault_o    = 1'b0;
      mem_address_o   = 32'h0;
      mem_wdata_o     = 32'h0;
      mem_wr_en_o     = 4'b0000;
      mem_load_type_o = 2'b00;
      mem_read_o      = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               store_d  = req_store_i;
               funct3_d = req_funct3_i;
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               state_d  = ACC0;
            end
         end
         ACC0: begin
            if (fault) begin
               state_d = RESP;
            end else begin
               mem_address_o   = word_addr;
               mem_load_type_o = 2'b10;
               if (store_q) begin
                  mem_wr_en_o = mask_sh[3:0];
                  mem_wdata_o = wdata_sh[31:0];
               end else begin
                  mem_read_o = 1'b1;
                  lo_d       = mem_rdata_i;
               end
`ifdef LSU_MISALIGNED_EN
               state_d = split ? ACC1 : RESP;
`else
               state_d = RESP;
`endif
            end
         end
         ACC1: begin
`ifdef LSU_MISALIGNED_EN
            mem_address_o   = next_word;
            mem_load_type_o = 2'b10;
            if (store_q) begin
               mem_wr_en_o = mask_sh[7:4];
               mem_wdata_o = wdata_sh[63:32];
            end else begin
               mem_read_o = 1'b1;
               hi_d       = mem_rdata_i;
            end
`endif
            state_d = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_fault_o = fault;
            resp_data_o  = (store_q || fault) ? 32'h0 : ext;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// compared against a byte-array memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_data;
   logic [31:0] mem_address, mem_wdata, mem_rdata;
   logic [3:0]  mem_wr_en;
   logic [1:0]  mem_load_type;
   logic        mem_read;
   logic        mem_init;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
      .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_fault_o(resp_fault),
      .mem_address_o(mem_address), .mem_wdata_o(mem_wdata), .mem_wr_en_o(mem_wr_en),
      .mem_load_type_o(mem_load_type), .mem_read_o(mem_read), .mem_rdata_i(mem_rdata)
   );

   // 4 KB word memory seen by the DUT; addresses alias modulo 4 KB.
   logic [31:0] dmem [0:1023];
   assign mem_rdata = dmem[mem_address[11:2]];

   function automatic logic [31:0] init_word(input int i);
      return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
      end else begin
         for (int i = 0; i < 4; i++)
            if (mem_wr_en[i]) dmem[mem_address[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   // Reference memory, byte granular.
   logic [7:0] ref_mem [0:4095];

   function automatic logic [31:0] refword(input logic [11:0] ba);
      logic [11:0] b;
      b = {ba[11:2], 2'b00};
      return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
   endfunction

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] obs_addr [0:7];
   logic [31:0] obs_wd   [0:7];
   logic [3:0]  obs_wr   [0:7];

   task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold,
                      output logic [31:0] rdata, output logic rfault);
      int sz, lat, cyc, act, busy_rdy;
      bit legal, split, fault;
      logic [31:0] v, expd;
      sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      split = (int'(a[1:0]) + sz) > 4;
      fault = !legal;
`ifndef LSU_MISALIGNED_EN
      if (split) fault = 1'b1;
`endif
      lat = (!fault && split) ? 3 : 2;
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[12'(a + 32'(i))];
      case (f3)
         3'd0:    expd = {{24{v[7]}}, v[7:0]};
         3'd1:    expd = {{16{v[15]}}, v[15:0]};
         3'd4:    expd = {24'h0, v[7:0]};
         3'd5:    expd = {16'h0, v[15:0]};
         default: expd = v;
      endcase
      if (st || fault) expd = 32'h0;

      @(negedge clk);
      check("ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(negedge clk);
      if (hold) begin
         req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h7F0; req_wdata = $urandom;
      end else begin
         req_valid = 1'b0;
      end
      cyc = 1; act = 0; busy_rdy = 0;
      while (!resp_valid && cyc < 8) begin
         obs_addr[cyc] = mem_address; obs_wd[cyc] = mem_wdata; obs_wr[cyc] = mem_wr_en;
         if (mem_read || mem_wr_en != 4'b0) act++;
         if (req_ready) busy_rdy++;
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      check("latency", 32'(cyc), 32'(lat));
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_fault", 32'(resp_fault), 32'(fault));
      check("resp_data", resp_data, expd);
      check("mem_activity", 32'(act), fault ? 32'd0 : 32'(lat - 1));
      check("busy_ready", 32'(busy_rdy), 32'd0);
      check("resp_mem_quiet", mem_address | mem_wdata | 32'(mem_wr_en) | 32'(mem_read), 32'h0);
      rdata  = resp_data;
      rfault = resp_fault;
      @(negedge clk);
      check("pulse_one_cycle", 32'(resp_valid), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);
      if (st && !fault) begin
         for (int i = 0; i < sz; i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
         check("mem_word_lo", dmem[a[11:2]], refword(a[11:0]));
         if (split) check("mem_word_hi", dmem[a[11:2] + 10'd1], refword(a[11:0] + 12'd4));
      end
      $display("txn st=%0d f3=%0d addr=%h wdata=%h -> data=%h fault=%0d cycles=%0d",
               st, f3, a, wd, rdata, rfault, cyc);
   endtask

   logic [31:0] r, w;
   logic        f;
   int          bad;

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 1024; i++) begin
         w = init_word(i);
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_fault", 32'(resp_fault), 32'd0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_mem_addr", mem_address, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_ctrl", {27'h0, mem_wr_en, mem_read}, 32'h0);
      check("rst_load_type", 32'(mem_load_type), 32'h0);
      @(negedge clk);
      reset = 1'b0; mem_init = 1'b0;

      // Word store / load
      txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, r, f);
      check("sw_wr_en", 32'(obs_wr[1]), 32'hF);
      check("sw_addr", obs_addr[1], 32'h100);
      txn(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, r, f);
      check("lw_data", r, 32'hDEADBEEF);

      // Byte store at lane 3, signed and unsigned reload
      txn(1'b1, 3'd0, 32'h103, 32'h00000080, 1'b0, r, f);
      check("sb_wr_en", 32'(obs_wr[1]), 32'b1000);
      check("sb_wdata", obs_wd[1], 32'h80000000);
      txn(1'b0, 3'd0, 32'h103, 32'h0, 1'b0, r, f);
      check("lb_data", r, 32'hFFFFFF80);
      txn(1'b0, 3'd4, 32'h103, 32'h0, 1'b0, r, f);
      check("lbu_data", r, 32'h00000080);

`ifdef LSU_MISALIGNED_EN
      txn(1'b1, 3'd2, 32'h201, 32'h11223344, 1'b0, r, f);
      check("split_acc0_addr", obs_addr[1], 32'h200);
      check("split_acc0_mask", 32'(obs_wr[1]), 32'b1110);
      check("split_acc1_addr", obs_addr[2], 32'h204);
      check("split_acc1_mask", 32'(obs_wr[2]), 32'b0001);
      txn(1'b0, 3'd2, 32'h201, 32'h0, 1'b0, r, f);
      check("split_lw_data", r, 32'h11223344);
      txn(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b0, r, f);
      check("wrap_hi_addr", obs_addr[2], 32'h0);
`else
      txn(1'b0, 3'd1, 32'h003, 32'h0, 1'b0, r, f);
      check("lh3_fault", 32'(f), 32'd1);
      txn(1'b1, 3'd2, 32'h005, 32'h12345678, 1'b0, r, f);
      check("sw5_fault", 32'(f), 32'd1);
      txn(1'b0, 3'd1, 32'h002, 32'h0, 1'b0, r, f);
      check("lh2_ok", 32'(f), 32'd0);
`endif
      txn(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b0, r, f);
      check("top_word_addr", obs_addr[1], 32'hFFFFFFFC);

      // Illegal funct3 with a request held on the bus while busy
      txn(1'b0, 3'd3, 32'h040, 32'h0, 1'b1, r, f);
      check("illegal_fault", 32'(f), 32'd1);
      txn(1'b1, 3'd4, 32'h044, 32'hA5A5A5A5, 1'b1, r, f);
      check("illegal_store_fault", 32'(f), 32'd1);

      // Reset in the middle of an aligned store access
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b0;
      check("acc0_write_seen", 32'(mem_wr_en), 32'hF);
      reset = 1'b1;
      #1;
      check("rst_acc0_wr_en", 32'(mem_wr_en), 32'h0);
      check("rst_acc0_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      check("rst_acc0_no_write", dmem[32'h300 >> 2], refword(12'h300));
      repeat (2) begin
         @(negedge clk);
         check("rst_acc0_no_resp", 32'(resp_valid), 32'd0);
      end

`ifdef LSU_MISALIGNED_EN
      // Reset during the second beat of a split store
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h301; req_wdata = 32'h99AABBCC;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("acc1_mask_seen", 32'(mem_wr_en), 32'b0001);
      reset = 1'b1;
      #1;
      check("rst_acc1_wr_en", 32'(mem_wr_en), 32'h0);
      check("rst_acc1_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_acc1_hi_unchanged", dmem[32'h304 >> 2], refword(12'h304));
      ref_mem[12'h301] = 8'hCC; ref_mem[12'h302] = 8'hBB; ref_mem[12'h303] = 8'hAA;
      check("rst_acc1_lo_written", dmem[32'h300 >> 2], refword(12'h300));
      @(negedge clk);
      check("rst_acc1_ready", 32'(req_ready), 32'd1);
      check("rst_acc1_no_resp", 32'(resp_valid), 32'd0);
`endif

      // Random traffic
      for (int n = 0; n < 80; n++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                          : 32'($urandom_range(0, 4095));
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
             1'($urandom_range(0, 1)), r, f);
      end

      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (dmem[i] !== refword(12'(4 * i))) bad++;
      check("final_mem_words_bad", 32'(bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk input 1, clock; reset input 1, asynchronous, active-high.
REQ-002 SHALL have req_valid input 1, pipeline request present.
REQ-003 SHALL have req_ready output 1, unit can accept a request.
REQ-004 SHALL have req_store input 1, 1=store, 0=load.
REQ-005 SHALL have req_funct3 input 3, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have req_addr input 32, byte address; req_wdata input 32, store data (low bytes significant).
REQ-007 SHALL have resp_valid output 1, one-cycle completion pulse; resp_data output 32, extended load data; resp_fault output 1, access fault.
REQ-008 SHALL have mem_address output 32, mem_wdata output 32, mem_wr_en output 4, mem_load_type output 2, mem_read output 1, mem_rdata input 32; memory reads combinationally, writes on posedge.

Function
REQ-009 SHALL implement states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL latch the request in IDLE when req_valid&&req_ready and go to ACC0; req_valid outside IDLE SHALL be ignored.
REQ-011 SHALL in ACC0 drive mem_address=req_addr&~3, mem_load_type=2'b10; loads: mem_read=1, mem_wr_en=0; stores: mem_read=0.
REQ-012 SHALL form store mask 0001/0011/1111 (B/H/W), mem_wr_en=(mask<<off)[3:0], mem_wdata=wdata<<(8*off), off=addr[1:0].
REQ-013 SHALL in ACC0 capture mem_rdata into lo register on loads.
REQ-014 SHALL classify an access as split when off+size>4 (H at off 3; W at off 1-3); non-split goes ACC0->RESP, split goes ACC0->ACC1->RESP.
REQ-015 SHALL in ACC1 drive mem_address=(addr&~3)+4, mem_wr_en=mask>>(4-off), mem_wdata=wdata>>(8*(4-off)), capture mem_rdata into hi register on loads.
REQ-016 SHALL in RESP assert resp_valid for exactly one cycle, extract bytes {hi,lo}>>(8*off), sign-extend for 000/001, zero-extend for 100/101, pass 010 unchanged; stores give resp_data=0; then return IDLE.
REQ-017 SHALL treat funct3 011/110/111 (load) or any funct3 other than 000/001/010 (store) as illegal: no memory activity, ACC0->RESP with resp_fault=1, resp_data=0.
REQ-018 SHALL keep mem_read=0, mem_wr_en=0, mem_address=0, mem_wdata=0 in IDLE and RESP.
REQ-019 Latency: aligned 2 cycles accept-to-resp_valid, split 3 cycles; next request acceptable the cycle after RESP.
REQ-020 Address arithmetic SHALL wrap modulo 2^32 (0xFFFFFFFC+4=0).

Reset
REQ-021 Reset SHALL force IDLE immediately; req_ready=1, resp_valid=0, resp_fault=0, resp_data=0, all mem_* outputs 0.
REQ-022 Reset mid-ACC0/ACC1 SHALL abort without a response and deassert mem_wr_en within the same cycle (no partial second write).

Configuration
REQ-023 Macro LSU_MISALIGNED_EN defined: split accesses per REQ-014/015.
REQ-024 Macro LSU_MISALIGNED_EN undefined: ACC1 not reachable; split accesses fault per REQ-017 semantics (no memory write, resp_fault=1); unsplit misaligned accesses (e.g. LB off 3, LH off 2) remain legal.

Verification
REQ-025 SW 0xDEADBEEF @0x100, then LW @0x100 -> stores mem_wr_en=1111; load resp_data=0xDEADBEEF 2 cycles after accept.
REQ-026 SB 0x80 @0x103, then LB @0x103 and LBU @0x103 -> mem_wr_en=1000, mem_wdata=0x80000000; resp_data 0xFFFFFF80 and 0x00000080.
REQ-027 With LSU_MISALIGNED_EN: SW 0x11223344 @0x201 -> ACC0 mask 1110 @0x200, ACC1 mask 0001 @0x204; LW @0x201 returns 0x11223344 in 3 cycles.
REQ-028 Without LSU_MISALIGNED_EN: LH @0x003 -> no mem_read/mem_wr_en activity, resp_fault=1, resp_data=0; LH @0x002 succeeds.
REQ-029 Load funct3=011 -> resp_fault=1, no memory access; back-to-back req_valid during busy states ignored, accepted only in IDLE.
REQ-030 Assert reset during ACC1 of split SW -> mem_wr_en=0 immediately, no resp_valid, high word unchanged, req_ready=1 after release.
